// File: rtl/regbank_pkg.sv
// Shared types and constants for the register-bank write arbiter.
// Stack-op encodings, stall states and default sizes.
package regbank_pkg;

  typedef enum logic [1:0] {
    STK_NOP  = 2'b00,
    STK_POP  = 2'b01,
    STK_PUSH = 2'b10
  } stk_op_e;

  typedef enum logic [1:0] {
    STALL_0 = 2'b00,
    STALL_1 = 2'b01,
    STALL_2 = 2'b10
  } stall_e;

  localparam int unsigned SP_IDX_DEFAULT = 29;
  localparam int unsigned REG_W          = 32;

  // Only pop and push actually move SP; 00 and 11 are accepted as no-ops.
  function automatic logic is_sp_move(input logic [1:0] op);
    return (op == STK_POP) || (op == STK_PUSH);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with a rotating priority pointer.
// Masked requesters are ignored; the pointer advances past the winner.
module rr_arbiter #(
  parameter int unsigned N = 3,
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [N-1:0]  req,
  input  logic [N-1:0]  mask,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx,
  output logic          grant_valid
);

  logic [IW-1:0] ptr_q, ptr_d;
  logic [IW-1:0] idx;
  logic [N-1:0]  eligible;

  always_comb begin
    eligible    = req & ~mask;
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    idx         = '0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = IW'((32'(ptr_q) + k) % N);
      if (!grant_valid && eligible[idx]) begin
        grant[idx]  = 1'b1;
        grant_idx   = idx;
        grant_valid = 1'b1;
      end
    end

    ptr_d = ptr_q;
    if (grant_valid) begin
      ptr_d = (32'(grant_idx) == N - 1) ? '0 : grant_idx + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/regbank_write_arbiter.sv
// Shares the register bank write port and stack-pointer op port between
// NREQ writeback requesters and the stack unit, serialising SP conflicts.
module regbank_write_arbiter
  import regbank_pkg::*;
#(
  parameter int unsigned NREQ   = 3,
  parameter int unsigned AW     = 5,
  parameter int unsigned DW     = REG_W,
  parameter int unsigned SP_IDX = SP_IDX_DEFAULT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]    req_ready,
  input  logic               stk_valid,
  input  logic [1:0]         stk_op,
  output logic               stk_ready,
  output logic               rb_write,
  output logic [AW-1:0]      rb_addr,
  output logic [DW-1:0]      rb_data,
  output logic [1:0]         rb_stackOp,
  output logic [2:0]         grant_id,
  output logic [15:0]        sp_conflicts
);

  localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0] sp_hit;
  logic [NREQ-1:0] arb_mask;
  logic [NREQ-1:0] grant;
  logic [IW-1:0]   grant_idx;
  logic            grant_valid;
  logic [AW-1:0]   sel_addr;
  logic [DW-1:0]   sel_data;
  logic            stk_active;
  logic            conflict;
  logic            stk_accept;

  stall_e          stall_q, stall_d;
  logic            rb_write_q, rb_write_d;
  logic [AW-1:0]   rb_addr_q, rb_addr_d;
  logic [DW-1:0]   rb_data_q, rb_data_d;
  logic [1:0]      rb_stackop_q, rb_stackop_d;
  logic [2:0]      grant_id_q, grant_id_d;
  logic [15:0]     sp_conflicts_q, sp_conflicts_d;

  always_comb begin
    sp_hit   = '0;
    sel_addr = '0;
    sel_data = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      sp_hit[i] = (req_addr[i*AW +: AW] == AW'(SP_IDX));
      if (grant[i]) begin
        sel_addr = req_addr[i*AW +: AW];
        sel_data = req_data[i*DW +: DW];
      end
    end
  end

  // After two lost conflicts the stack op wins: SP writers sit out this cycle.
  assign stk_active = stk_valid && is_sp_move(stk_op);
  assign arb_mask   = (stk_active && stall_q == STALL_2) ? sp_hit : '0;

  rr_arbiter #(
    .N(NREQ)
  ) u_rr_arbiter (
    .clk        (clk),
    .reset      (reset),
    .req        (req_valid),
    .mask       (arb_mask),
    .grant      (grant),
    .grant_idx  (grant_idx),
    .grant_valid(grant_valid)
  );

  assign conflict   = stk_active && (stall_q != STALL_2) && grant_valid
                      && (sel_addr == AW'(SP_IDX));
  assign stk_accept = !reset && stk_valid && !conflict;
  assign req_ready  = reset ? '0 : grant;
  assign stk_ready  = stk_accept;

  always_comb begin
    stall_d = stall_q;
    if (stk_accept) begin
      stall_d = STALL_0;
    end else if (conflict) begin
      case (stall_q)
        STALL_0: stall_d = STALL_1;
        STALL_1: stall_d = STALL_2;
        default: stall_d = stall_q;
      endcase
    end
  end

  always_comb begin
    rb_write_d     = grant_valid && (sel_addr != '0);
    rb_addr_d      = grant_valid ? sel_addr : rb_addr_q;
    rb_data_d      = grant_valid ? sel_data : rb_data_q;
    grant_id_d     = grant_valid ? 3'(grant_idx) : grant_id_q;
    rb_stackop_d   = (stk_accept && stk_active) ? stk_op : STK_NOP;
    sp_conflicts_d = sp_conflicts_q;
    if (conflict && sp_conflicts_q != 16'hFFFF) begin
      sp_conflicts_d = sp_conflicts_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_q        <= STALL_0;
      rb_write_q     <= 1'b0;
      rb_addr_q      <= '0;
      rb_data_q      <= '0;
      rb_stackop_q   <= '0;
      grant_id_q     <= '0;
      sp_conflicts_q <= '0;
    end else begin
      stall_q        <= stall_d;
      rb_write_q     <= rb_write_d;
      rb_addr_q      <= rb_addr_d;
      rb_data_q      <= rb_data_d;
      rb_stackop_q   <= rb_stackop_d;
      grant_id_q     <= grant_id_d;
      sp_conflicts_q <= sp_conflicts_d;
    end
  end

  assign rb_write     = rb_write_q;
  assign rb_addr      = rb_addr_q;
  assign rb_data      = rb_data_q;
  assign rb_stackOp   = rb_stackop_q;
  assign grant_id     = grant_id_q;
  assign sp_conflicts = sp_conflicts_q;

endmodule

// File: tb/tb_regbank_write_arbiter.sv
// Bench for regbank_write_arbiter: directed vectors, a short handshake-respecting
// random phase, and a per-cycle comparison against a rule-level model.
module tb_regbank_write_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  req_valid;
  logic [14:0] req_addr;
  logic [95:0] req_data;
  logic [2:0]  req_ready;
  logic        stk_valid;
  logic [1:0]  stk_op;
  logic        stk_ready;
  logic        rb_write;
  logic [4:0]  rb_addr;
  logic [31:0] rb_data;
  logic [1:0]  rb_stackOp;
  logic [2:0]  grant_id;
  logic [15:0] sp_conflicts;

  logic [4:0]  a [3];
  logic [31:0] d [3];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      req_addr[i*5 +: 5]   = a[i];
      req_data[i*32 +: 32] = d[i];
    end
  end

  regbank_write_arbiter #(
    .NREQ  (3),
    .AW    (5),
    .DW    (32),
    .SP_IDX(29)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_addr    (req_addr),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .stk_valid   (stk_valid),
    .stk_op      (stk_op),
    .stk_ready   (stk_ready),
    .rb_write    (rb_write),
    .rb_addr     (rb_addr),
    .rb_data     (rb_data),
    .rb_stackOp  (rb_stackOp),
    .grant_id    (grant_id),
    .sp_conflicts(sp_conflicts)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit          m_ok = 1'b0;
  int          m_ptr, m_stall, e_gid, e_cnt;
  logic        e_write;
  logic [4:0]  e_addr;
  logic [31:0] e_data;
  logic [1:0]  e_stk;

  function automatic void predict(output int g, output bit conflict, output bit srdy);
    bit active, masked;
    int i;
    g = -1; conflict = 1'b0; srdy = 1'b0;
    if (reset) return;
    active = stk_valid && (stk_op == 2'b01 || stk_op == 2'b10);
    masked = active && (m_stall == 2);
    for (int k = 0; k < 3; k++) begin
      i = (m_ptr + k) % 3;
      if (g < 0 && req_valid[i] && !(masked && a[i] == 5'd29)) g = i;
    end
    conflict = active && (m_stall < 2) && (g >= 0) && (a[g] == 5'd29);
    srdy = stk_valid && !conflict;
  endfunction

  always @(posedge clk) begin
    int g;
    bit c, s;
    predict(g, c, s);
    if (reset) begin
      m_ok = 1'b1; m_ptr = 0; m_stall = 0;
      e_write = 1'b0; e_addr = '0; e_data = '0; e_stk = '0; e_gid = 0; e_cnt = 0;
    end else begin
      if (g >= 0) begin
        e_write = (a[g] != 5'd0);
        e_addr  = a[g];
        e_data  = d[g];
        e_gid   = g;
        m_ptr   = (g + 1) % 3;
      end else begin
        e_write = 1'b0;
      end
      e_stk = (s && (stk_op == 2'b01 || stk_op == 2'b10)) ? stk_op : 2'b00;
      if (c) begin
        m_stall++;
        if (e_cnt < 65535) e_cnt++;
      end
      if (stk_valid && s) m_stall = 0;
    end
  end

  // Single compare process: every falling edge once the model is anchored by reset.
  always @(negedge clk) begin
    int g;
    bit c, s;
    logic [2:0] ev;
    if (m_ok) begin
      predict(g, c, s);
      ev = (g >= 0) ? (3'b001 << g) : 3'b000;
      check("req_ready",    req_ready,    ev);
      check("stk_ready",    stk_ready,    s);
      check("rb_write",     rb_write,     e_write);
      check("rb_addr",      rb_addr,      e_addr);
      check("rb_data",      rb_data,      e_data);
      check("rb_stackOp",   rb_stackOp,   e_stk);
      check("grant_id",     grant_id,     e_gid);
      check("sp_conflicts", sp_conflicts, e_cnt);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  logic [4:0] addr_pool [5];
  logic [2:0] rdy;
  logic       srdy;

  initial begin
    addr_pool[0] = 5'd0;  addr_pool[1] = 5'd29; addr_pool[2] = 5'd29;
    addr_pool[3] = 5'd3;  addr_pool[4] = 5'd17;

    // Reset with every requester valid
    reset = 1'b1; req_valid = 3'b111; stk_valid = 1'b0; stk_op = 2'b00;
    a[0] = 5'd5; a[1] = 5'd6; a[2] = 5'd7;
    d[0] = 32'h100; d[1] = 32'h101; d[2] = 32'h102;
    tick(); #1;
    check("lit_rst1_ready", req_ready, 3'b000);
    check("lit_rst1_write", rb_write, 1'b0);
    tick(); #1;
    check("lit_rst2_ready", req_ready, 3'b000);
    check("lit_rst2_stk_ready", stk_ready, 1'b0);
    check("lit_rst2_write", rb_write, 1'b0);
    check("lit_rst2_stackop", rb_stackOp, 2'b00);
    check("lit_rst2_cnt", sp_conflicts, 16'd0);

    // Round-robin 0,1,2,0
    reset = 1'b0; #1;
    check("lit_rr_ready0", req_ready, 3'b001);
    tick(); #1;
    check("lit_rr_addr0", rb_addr, 5'd5);
    check("lit_rr_ready1", req_ready, 3'b010);
    tick(); #1;
    check("lit_rr_addr1", rb_addr, 5'd6);
    check("lit_rr_ready2", req_ready, 3'b100);
    tick(); #1;
    check("lit_rr_addr2", rb_addr, 5'd7);
    check("lit_rr_gid2", grant_id, 3'd2);
    check("lit_rr_ready3", req_ready, 3'b001);
    tick(); #1;
    check("lit_rr_addr3", rb_addr, 5'd5);
    check("lit_rr_data3", rb_data, 32'h100);

    // Register 0 write is accepted but not committed
    req_valid = 3'b001; a[0] = 5'd0; d[0] = 32'hDEAD; #1;
    check("lit_r0_ready", req_ready, 3'b001);
    tick(); #1;
    check("lit_r0_write", rb_write, 1'b0);
    check("lit_r0_addr", rb_addr, 5'd0);
    check("lit_r0_data", rb_data, 32'hDEAD);

    // Write and push in parallel
    req_valid = 3'b010; a[1] = 5'd8; d[1] = 32'h88; stk_valid = 1'b1; stk_op = 2'b10; #1;
    check("lit_par_ready", req_ready, 3'b010);
    check("lit_par_stk_ready", stk_ready, 1'b1);
    tick(); #1;
    check("lit_par_write", rb_write, 1'b1);
    check("lit_par_addr", rb_addr, 5'd8);
    check("lit_par_stackop", rb_stackOp, 2'b10);

    // SP conflict: write wins twice, then the pop
    req_valid = 3'b001; a[0] = 5'd29; d[0] = 32'h29; stk_valid = 1'b1; stk_op = 2'b01; #1;
    check("lit_sp_ready1", req_ready, 3'b001);
    check("lit_sp_stk1", stk_ready, 1'b0);
    tick(); #1;
    check("lit_sp_cnt1", sp_conflicts, 16'd1);
    check("lit_sp_stk2", stk_ready, 1'b0);
    tick(); #1;
    check("lit_sp_cnt2", sp_conflicts, 16'd2);
    check("lit_sp_ready3", req_ready, 3'b000);
    check("lit_sp_stk3", stk_ready, 1'b1);
    tick(); #1;
    check("lit_sp_stackop", rb_stackOp, 2'b01);
    check("lit_sp_write", rb_write, 1'b0);
    check("lit_sp_stk4", stk_ready, 1'b0);
    req_valid = 3'b000; stk_valid = 1'b0;
    tick();

    // Reset on the cycle after a grant
    req_valid = 3'b111; a[0] = 5'd5; a[1] = 5'd6; a[2] = 5'd7; #1;
    tick();
    reset = 1'b1; #1;
    check("lit_mid_ready", req_ready, 3'b000);
    tick(); #1;
    check("lit_mid_write", rb_write, 1'b0);
    check("lit_mid_addr", rb_addr, 5'd0);
    check("lit_mid_data", rb_data, 32'd0);
    check("lit_mid_gid", grant_id, 3'd0);
    check("lit_mid_cnt", sp_conflicts, 16'd0);
    reset = 1'b0; #1;
    check("lit_mid_first", req_ready, 3'b001);

    // Random traffic that honours the valid/ready handshake
    req_valid = 3'b000; stk_valid = 1'b0;
    tick();
    for (int cyc = 0; cyc < 120; cyc++) begin
      for (int i = 0; i < 3; i++) begin
        if (!req_valid[i] && $urandom_range(0, 2) != 0) begin
          req_valid[i] = 1'b1;
          a[i] = addr_pool[$urandom_range(0, 4)];
          d[i] = $urandom;
        end
      end
      if (!stk_valid && $urandom_range(0, 2) != 0) begin
        stk_valid = 1'b1;
        stk_op = 2'($urandom_range(0, 3));
      end
      #1;
      rdy  = req_ready;
      srdy = stk_ready;
      tick();
      for (int i = 0; i < 3; i++) if (rdy[i]) req_valid[i] = 1'b0;
      if (srdy) stk_valid = 1'b0;
    end

    req_valid = 3'b000; stk_valid = 1'b0;
    tick(); tick();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
